// File: rtl/lsu_controller_if.sv
// Core-request and memory-side signal bundle of the load/store unit.
// The controller uses the slave view; the core/memory environment drives through master.
interface lsu_controller_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
               mem_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
               mem_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/lsu_controller.sv
// Single-outstanding load/store controller: alignment check, lane steering,
// load extension and an access timeout between a core port and a word memory.
module lsu_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    lsu_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    function automatic logic req_error(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   req_error = 1'b0;
            2'b01:   req_error = off[0];
            2'b10:   req_error = (off != 2'b00);
            default: req_error = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   lane_wdata = {4{wdata[7:0]}};
            2'b01:   lane_wdata = {2{wdata[15:0]}};
            default: lane_wdata = wdata;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = 4'b0011 << off;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                                input logic [1:0] off, input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> {off, 3'b000};
        case (size)
            2'b00:   load_extend = {{24{~uns & v[7]}}, v[7:0]};
            2'b01:   load_extend = {{16{~uns & v[15]}}, v[15:0]};
            default: load_extend = rdata;
        endcase
    endfunction

    // Control state resets asynchronously; datapath holding registers are
    // masked by state at the outputs, so they need no reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
        off_q   <= off_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        rdata_q <= rdata_d;
        err_q   <= err_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    off_d   = bus.req_addr[1:0];
                    addr_d  = {bus.req_addr[31:2], 2'b00};
                    wdata_d = lane_wdata(bus.req_size, bus.req_wdata);
                    be_d    = bus.req_we ? lane_be(bus.req_size, bus.req_addr[1:0]) : 4'b0000;
                    rdata_d = 32'd0;
                    cnt_d   = 16'd0;
                    if (req_error(bus.req_size, bus.req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A ready response in the timeout cycle still completes cleanly.
                if (bus.mem_ready) begin
                    rdata_d = we_q ? 32'd0 : load_extend(size_q, uns_q, off_q, bus.mem_rdata);
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q + 16'd1 == TIMEOUT_LIMIT) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == IDLE) && !rst;
        bus.mem_req    = (state_q == ACCESS);
        bus.mem_we     = (state_q == ACCESS) && we_q;
        bus.mem_addr   = (state_q == ACCESS) ? addr_q  : 32'd0;
        bus.mem_wdata  = (state_q == ACCESS) ? wdata_q : 32'd0;
        bus.mem_be     = (state_q == ACCESS) ? be_q    : 4'b0000;
        bus.resp_valid = (state_q == RESP);
        bus.resp_err   = (state_q == RESP) && err_q;
        bus.resp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
    end
endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: loads, stores, alignment errors,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_lsu_controller;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    lsu_controller_if bus ();

    lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;

        tick;
        tick;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Signed byte load, ready held high from before acceptance
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h80FF_0000;
        drive_req(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'd0);
        tick;
        bus.req_valid = 1'b0;
        chk("lb_mem_req", 32'(bus.mem_req), 32'd1);
        chk("lb_mem_addr", bus.mem_addr, 32'h0000_1000);
        chk("lb_mem_be", 32'(bus.mem_be), 32'd0);
        chk("lb_mem_we", 32'(bus.mem_we), 32'd0);
        chk("lb_early_resp", 32'(bus.resp_valid), 32'd0);
        tick;
        chk("lb_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("lb_rdata", bus.resp_rdata, 32'hFFFF_FF80);
        chk("lb_err", 32'(bus.resp_err), 32'd0);
        chk("lb_mem_req_off", 32'(bus.mem_req), 32'd0);
        tick;
        chk("lb_resp_pulse", 32'(bus.resp_valid), 32'd0);
        chk("lb_rdata_idle", bus.resp_rdata, 32'd0);
        chk("lb_ready_again", 32'(bus.req_ready), 32'd1);

        // Unsigned half load with one wait cycle
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hBEEF_1234;
        drive_req(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'd0);
        tick;
        bus.req_valid = 1'b0;
        chk("lhu_mem_addr", bus.mem_addr, 32'h0000_0000);
        tick;
        chk("lhu_wait_req", 32'(bus.mem_req), 32'd1);
        chk("lhu_wait_resp", 32'(bus.resp_valid), 32'd0);
        bus.mem_ready = 1'b1;
        tick;
        chk("lhu_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("lhu_rdata", bus.resp_rdata, 32'h0000_BEEF);
        tick;

        // Signed half load at offset 0
        bus.mem_rdata = 32'h1234_8001;
        drive_req(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'd0);
        tick;
        bus.req_valid = 1'b0;
        tick;
        chk("lh_rdata", bus.resp_rdata, 32'hFFFF_8001);
        tick;

        // Byte store at offset 1
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        drive_req(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_00AB);
        tick;
        bus.req_valid = 1'b0;
        chk("sb_mem_addr", bus.mem_addr, 32'h0000_0000);
        chk("sb_mem_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        chk("sb_mem_be", 32'(bus.mem_be), 32'h2);
        chk("sb_mem_we", 32'(bus.mem_we), 32'd1);
        bus.mem_ready = 1'b1;
        tick;
        chk("sb_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("sb_rdata", bus.resp_rdata, 32'd0);
        chk("sb_err", 32'(bus.resp_err), 32'd0);
        tick;

        // Half and word stores
        drive_req(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h1234_CAFE);
        tick;
        bus.req_valid = 1'b0;
        chk("sh_mem_addr", bus.mem_addr, 32'h0000_0004);
        chk("sh_mem_wdata", bus.mem_wdata, 32'hCAFE_CAFE);
        chk("sh_mem_be", 32'(bus.mem_be), 32'hC);
        tick;
        tick;
        drive_req(1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'h1234_5678);
        tick;
        bus.req_valid = 1'b0;
        chk("sw_mem_addr", bus.mem_addr, 32'h0000_0104);
        chk("sw_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        chk("sw_mem_be", 32'(bus.mem_be), 32'hF);
        tick;
        tick;

        // Misaligned word load errors without touching memory
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'd0);
        tick;
        bus.req_valid = 1'b0;
        chk("lw_mis_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("lw_mis_err", 32'(bus.resp_err), 32'd1);
        chk("lw_mis_rdata", bus.resp_rdata, 32'd0);
        chk("lw_mis_mem_req", 32'(bus.mem_req), 32'd0);
        tick;
        chk("lw_mis_mem_req2", 32'(bus.mem_req), 32'd0);
        chk("lw_mis_pulse", 32'(bus.resp_valid), 32'd0);

        // Back-to-back errors: misaligned half then illegal size, valid held
        drive_req(1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'd0);
        tick;
        chk("lh_mis_err", 32'(bus.resp_err), 32'd1);
        bus.req_size = 2'b11;
        bus.req_addr = 32'h0000_0000;
        tick;
        chk("b2b_idle_ready", 32'(bus.req_ready), 32'd1);
        chk("b2b_idle_resp", 32'(bus.resp_valid), 32'd0);
        tick;
        bus.req_valid = 1'b0;
        chk("ill_size_valid", 32'(bus.resp_valid), 32'd1);
        chk("ill_size_err", 32'(bus.resp_err), 32'd1);
        chk("ill_size_mem_req", 32'(bus.mem_req), 32'd0);
        tick;

        // Timeout: mem_req high for exactly four cycles
        bus.mem_ready = 1'b0;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'd0);
        tick;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_mem_req", 32'(bus.mem_req), 32'd1);
            chk("to_no_resp", 32'(bus.resp_valid), 32'd0);
            tick;
        end
        chk("to_mem_req_off", 32'(bus.mem_req), 32'd0);
        chk("to_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("to_err", 32'(bus.resp_err), 32'd1);
        chk("to_rdata", bus.resp_rdata, 32'd0);
        tick;

        // Ready arriving in the timeout cycle wins
        bus.mem_rdata = 32'h1122_3344;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'd0);
        tick;
        bus.req_valid = 1'b0;
        tick;
        tick;
        tick;
        chk("race_mem_req", 32'(bus.mem_req), 32'd1);
        bus.mem_ready = 1'b1;
        tick;
        chk("race_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("race_err", 32'(bus.resp_err), 32'd0);
        chk("race_rdata", bus.resp_rdata, 32'h1122_3344);
        tick;

        // Asynchronous reset during ACCESS
        bus.mem_ready = 1'b0;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'd0);
        tick;
        bus.req_valid = 1'b0;
        chk("ra_mem_req_before", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("ra_mem_req_async", 32'(bus.mem_req), 32'd0);
        chk("ra_ready_in_rst", 32'(bus.req_ready), 32'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("ra_ready_release", 32'(bus.req_ready), 32'd1);
        bus.mem_ready = 1'b1;
        tick;
        chk("ra_no_resp", 32'(bus.resp_valid), 32'd0);
        chk("ra_no_mem_req", 32'(bus.mem_req), 32'd0);
        bus.mem_ready = 1'b0;

        // Asynchronous reset during RESP
        drive_req(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'd0);
        tick;
        bus.req_valid = 1'b0;
        chk("rr_resp_before", 32'(bus.resp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rr_resp_async", 32'(bus.resp_valid), 32'd0);
        chk("rr_err_async", 32'(bus.resp_err), 32'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("rr_ready_release", 32'(bus.req_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
